// File: rtl/param_bank_control.sv
// -----------------------------------------------------------------------------
// param_bank_control
//
// Push-button front end for a bank of N_CH bounded integer set-points. Three
// active-low board keys (increment, decrement, channel select) are
// synchronised and debounced. Their press events step the selected channel
// with saturation or advance the selection. A small step FSM owns the
// direction keys. It resolves simultaneous presses and, when
// PARAM_BANK_AUTOREPEAT_EN is defined, auto-repeats a held key after
// HOLD_CYCLES and then every REPEAT_CYCLES.
//
// Configuration macro:
//   PARAM_BANK_AUTOREPEAT_EN  defined   : HOLD/REPEAT states and hold timer present
//                             undefined : a press steps once, then LOCK until release
//
// Ports:
//   i_CLK     in   1            system clock
//   i_RST     in   1            asynchronous active-low reset
//   inc_btn   in   1            increment key, active-low, asynchronous
//   dec_btn   in   1            decrement key, active-low, asynchronous
//   sel_btn   in   1            channel-select key, active-low, asynchronous
//   o_values  out  N_CH*N_BIT   packed channel values, channel k at [k*N_BIT +: N_BIT]
//   o_sel     out  SEL_W        selected channel index
//   o_cur     out  N_BIT        value of the selected channel (combinational)
//   o_upd     out  1            one-cycle pulse per channel register write
//   o_dir     out  1            direction of the last write (1 inc, 0 dec)
// -----------------------------------------------------------------------------
module param_bank_control #(
    parameter int N_CH          = 4,
    parameter int SEL_W         = 2,
    parameter int N_BIT         = 8,
    parameter int INTEGER_STEP  = 1,
    parameter int INTEGER_MIN   = 0,
    parameter int INTEGER_MAX   = 255,
    parameter int INTEGER_RST   = 0,
    parameter int DEB_CYCLES    = 50000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic                   i_CLK,
    input  logic                   i_RST,
    input  logic                   inc_btn,
    input  logic                   dec_btn,
    input  logic                   sel_btn,
    output logic [N_CH*N_BIT-1:0]  o_values,
    output logic [SEL_W-1:0]       o_sel,
    output logic [N_BIT-1:0]       o_cur,
    output logic                   o_upd,
    output logic                   o_dir
);

    // Bit positions of the three keys inside the per-key vectors.
    localparam int KEY_INC = 0;
    localparam int KEY_DEC = 1;
    localparam int KEY_SEL = 2;

    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    // Step FSM encoding.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK   = 2'd3;
`ifdef PARAM_BANK_AUTOREPEAT_EN
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
`endif

    // Step arithmetic is done one bit wider than a channel so that an
    // increment past the top of the range cannot wrap before the clamp.
    localparam int              VW     = N_BIT + 1;
    localparam logic [VW-1:0]   STEP_V = VW'(INTEGER_STEP);
    localparam logic [VW-1:0]   MIN_V  = VW'(INTEGER_MIN);
    localparam logic [VW-1:0]   MAX_V  = VW'(INTEGER_MAX);

    // -------------------------------------------------------------------------
    // Synchroniser, debouncer and edge detector for all three keys.
    // -------------------------------------------------------------------------
    logic [2:0]       raw;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       db;
    logic [2:0]       db_prev;
    logic [2:0]       press;
    logic [DEB_W-1:0] deb_cnt [3];

    assign raw = {sel_btn, dec_btn, inc_btn};

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            sync1   <= '1;
            sync2   <= '1;
            db      <= '1;
            db_prev <= '1;
            press   <= '0;
            for (int k = 0; k < 3; k++) begin
                deb_cnt[k] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            db_prev <= db;
            // Registered 1->0 transition of the debounced level.
            press   <= db_prev & ~db;
            for (int k = 0; k < 3; k++) begin
                if (sync2[k] == db[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_W'(DEB_CYCLES)) begin
                    db[k]      <= sync2[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + DEB_W'(1);
                end
            end
        end
    end

    logic inc_press;
    logic dec_press;
    logic sel_press;
    logic dir_idle;

    assign inc_press = press[KEY_INC];
    assign dec_press = press[KEY_DEC];
    assign sel_press = press[KEY_SEL];
    // Both direction keys released (debounced).
    assign dir_idle  = db[KEY_INC] & db[KEY_DEC];

    // -------------------------------------------------------------------------
    // Channel bank and saturating step.
    // -------------------------------------------------------------------------
    logic [N_BIT-1:0] vals [N_CH];
    logic [VW-1:0]    cur_w;
    logic [VW-1:0]    inc_sum;
    logic [N_BIT-1:0] inc_val;
    logic [N_BIT-1:0] dec_val;

    assign o_cur   = vals[o_sel];
    assign cur_w   = {1'b0, o_cur};
    assign inc_sum = cur_w + STEP_V;

    always_comb begin
        inc_val = inc_sum[N_BIT-1:0];
        if (inc_sum > MAX_V) begin
            inc_val = MAX_V[N_BIT-1:0];
        end
    end

    always_comb begin
        dec_val = N_BIT'(cur_w - STEP_V);
        if (cur_w < MIN_V + STEP_V) begin
            dec_val = MIN_V[N_BIT-1:0];
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_pack
        assign o_values[k*N_BIT +: N_BIT] = vals[k];
    end

    // -------------------------------------------------------------------------
    // Step FSM.
    // -------------------------------------------------------------------------
    logic [1:0] state;
    logic [1:0] state_n;
    logic       we;
    logic       we_dir;
    logic       sel_adv;
`ifdef PARAM_BANK_AUTOREPEAT_EN
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_n;
    logic             owner_dec;
    logic             owner_dec_n;
    logic             owner_released;

    assign owner_released = owner_dec ? db[KEY_DEC] : db[KEY_INC];
`endif

    // NOTE: every signal written below gets a default first, so no path
    // through the block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        we      = 1'b0;
        we_dir  = 1'b1;
        sel_adv = 1'b0;
`ifdef PARAM_BANK_AUTOREPEAT_EN
        tmr_n       = tmr;
        owner_dec_n = owner_dec;
`endif
        if (sel_press) begin
            // Selection wins over any direction press in the same cycle.
            // A key still held must be released before it can step the new
            // channel.
            sel_adv = 1'b1;
            state_n = dir_idle ? ST_IDLE : ST_LOCK;
`ifdef PARAM_BANK_AUTOREPEAT_EN
            tmr_n   = '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inc_press && dec_press) begin
                        state_n = ST_LOCK;
                    end else if (inc_press || dec_press) begin
                        we     = 1'b1;
                        we_dir = inc_press;
`ifdef PARAM_BANK_AUTOREPEAT_EN
                        owner_dec_n = dec_press;
                        tmr_n       = '0;
                        state_n     = ST_HOLD;
`else
                        state_n = ST_LOCK;
`endif
                    end
                end
`ifdef PARAM_BANK_AUTOREPEAT_EN
                ST_HOLD: begin
                    if (owner_released) begin
                        state_n = ST_IDLE;
                    end else if (tmr == TMR_W'(HOLD_CYCLES - 1)) begin
                        we      = 1'b1;
                        we_dir  = ~owner_dec;
                        tmr_n   = '0;
                        state_n = ST_REPEAT;
                    end else begin
                        tmr_n = tmr + TMR_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (owner_released) begin
                        state_n = ST_IDLE;
                    end else if (tmr == TMR_W'(REPEAT_CYCLES - 1)) begin
                        we     = 1'b1;
                        we_dir = ~owner_dec;
                        tmr_n  = '0;
                    end else begin
                        tmr_n = tmr + TMR_W'(1);
                    end
                end
`endif
                ST_LOCK: begin
                    if (dir_idle) begin
                        state_n = ST_IDLE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: the bank is N_CH small flop registers, not a RAM macro, so it is
    // reset along with the rest of the state.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state <= ST_IDLE;
            o_sel <= '0;
            o_upd <= 1'b0;
            o_dir <= 1'b1;
            for (int k = 0; k < N_CH; k++) begin
                vals[k] <= N_BIT'(INTEGER_RST);
            end
`ifdef PARAM_BANK_AUTOREPEAT_EN
            tmr       <= '0;
            owner_dec <= 1'b0;
`endif
        end else begin
            state <= state_n;
            o_upd <= we;
            if (we) begin
                vals[o_sel] <= we_dir ? inc_val : dec_val;
                o_dir       <= we_dir;
            end
            if (sel_adv) begin
                o_sel <= (o_sel == SEL_W'(N_CH - 1)) ? '0 : o_sel + SEL_W'(1);
            end
`ifdef PARAM_BANK_AUTOREPEAT_EN
            tmr       <= tmr_n;
            owner_dec <= owner_dec_n;
`endif
        end
    end

endmodule

// File: tb/tb_param_bank_control.sv
// -----------------------------------------------------------------------------
// tb_param_bank_control
//
// Directed bench for param_bank_control. Two instances share clock and reset:
//   dut_a : STEP=1, range 0..255, reset 0, DEB=4, HOLD=20, REPEAT=5
//   dut_b : STEP=2, range 0..255, reset 254 (saturation at both bounds)
// Inputs change on the falling edge, and outputs are sampled on the falling
// edge. Expected values are hand-computed. Auto-repeat expectations follow
// PARAM_BANK_AUTOREPEAT_EN.
// -----------------------------------------------------------------------------
module tb_param_bank_control;

    localparam int KEY_INC_A = 0;
    localparam int KEY_DEC_A = 1;
    localparam int KEY_SEL_A = 2;
    localparam int KEY_INC_B = 3;
    localparam int KEY_DEC_B = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc_a = 1'b1;
    logic        dec_a = 1'b1;
    logic        sel_a = 1'b1;
    logic        inc_b = 1'b1;
    logic        dec_b = 1'b1;
    logic        sel_b = 1'b1;

    logic [31:0] values_a;
    logic [31:0] values_b;
    logic [1:0]  selo_a;
    logic [1:0]  selo_b;
    logic [7:0]  cur_a;
    logic [7:0]  cur_b;
    logic        upd_a;
    logic        upd_b;
    logic        dir_a;
    logic        dir_b;

    int unsigned passed    = 0;
    int unsigned total     = 0;
    int unsigned fails     = 0;
    int unsigned upd_cnt_a = 0;
    int unsigned upd_cnt_b = 0;

    always #5 clk = ~clk;

    param_bank_control #(
        .N_CH(4), .SEL_W(2), .N_BIT(8), .INTEGER_STEP(1), .INTEGER_MIN(0),
        .INTEGER_MAX(255), .INTEGER_RST(0), .DEB_CYCLES(4), .HOLD_CYCLES(20),
        .REPEAT_CYCLES(5)
    ) dut_a (
        .i_CLK(clk), .i_RST(rst_n), .inc_btn(inc_a), .dec_btn(dec_a), .sel_btn(sel_a),
        .o_values(values_a), .o_sel(selo_a), .o_cur(cur_a), .o_upd(upd_a), .o_dir(dir_a)
    );

    param_bank_control #(
        .N_CH(4), .SEL_W(2), .N_BIT(8), .INTEGER_STEP(2), .INTEGER_MIN(0),
        .INTEGER_MAX(255), .INTEGER_RST(254), .DEB_CYCLES(4), .HOLD_CYCLES(20),
        .REPEAT_CYCLES(5)
    ) dut_b (
        .i_CLK(clk), .i_RST(rst_n), .inc_btn(inc_b), .dec_btn(dec_b), .sel_btn(sel_b),
        .o_values(values_b), .o_sel(selo_b), .o_cur(cur_b), .o_upd(upd_b), .o_dir(dir_b)
    );

    // Count every sampled update pulse.
    always @(negedge clk) begin
        if (upd_a) upd_cnt_a++;
        if (upd_b) upd_cnt_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_key(input int which, input logic level);
        case (which)
            KEY_INC_A: inc_a = level;
            KEY_DEC_A: dec_a = level;
            KEY_SEL_A: sel_a = level;
            KEY_INC_B: inc_b = level;
            KEY_DEC_B: dec_b = level;
            default:   ;
        endcase
    endtask

    // Press for 10 cycles (one step lands 9 samples in, well before any
    // auto-repeat), then release long enough to settle back to IDLE.
    task automatic tap(input int which);
        set_key(which, 1'b0);
        waitn(10);
        set_key(which, 1'b1);
        waitn(12);
    endtask

    initial begin
        int unsigned c0;
        int          nsteps;
        int          first;
        int          second;
        int          third;

        // ---- reset state ----
        waitn(3);
        check("rst_values", values_a, 32'h0);
        check("rst_sel", 32'(selo_a), 32'd0);
        check("rst_upd", 32'(upd_a), 32'd0);
        check("rst_dir", 32'(dir_a), 32'd1);
        check("rst_values_b", values_b, 32'hFEFE_FEFE);
        rst_n = 1'b1;
        waitn(2);

        // ---- single tap latency: raw low first sampled at edge 0, write after edge 8 ----
        inc_a = 1'b0;
        waitn(8);
        check("lat_before", 32'(values_a[7:0]), 32'd0);
        check("lat_upd_before", 32'(upd_a), 32'd0);
        waitn(1);
        check("lat_value", 32'(values_a[7:0]), 32'd1);
        check("lat_upd", 32'(upd_a), 32'd1);
        check("lat_dir", 32'(dir_a), 32'd1);
        check("lat_cur", 32'(cur_a), 32'd1);
        waitn(1);
        check("lat_upd_one_cycle", 32'(upd_a), 32'd0);
        inc_a = 1'b1;
        waitn(12);

        // ---- bounce: toggling every 2 cycles never survives a 4-cycle debounce ----
        c0 = upd_cnt_a;
        for (int i = 0; i < 5; i++) begin
            inc_a = 1'b0;
            waitn(2);
            inc_a = 1'b1;
            waitn(2);
        end
        inc_a = 1'b0;
        waitn(10);
        inc_a = 1'b1;
        waitn(12);
        check("bounce_steps", upd_cnt_a - c0, 32'd1);
        check("bounce_value", 32'(values_a[7:0]), 32'd2);

        // ---- selection wraps 1,2,3,0,1 ----
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_sel;
            tap(KEY_SEL_A);
            exp_sel = 2'((i + 1) % 4);
            check("sel_wrap", 32'(selo_a), 32'(exp_sel));
        end
        check("sel_values_kept", values_a, 32'h0000_0002);

        // ---- inc on ch1 touches only [15:8] ----
        tap(KEY_INC_A);
        check("ch1_inc", values_a, 32'h0000_0102);
        check("ch1_cur", 32'(cur_a), 32'd1);

        // ---- dec to the lower bound, then again at the bound ----
        tap(KEY_DEC_A);
        check("ch1_dec", values_a, 32'h0000_0002);
        check("ch1_dec_dir", 32'(dir_a), 32'd0);
        c0 = upd_cnt_a;
        tap(KEY_DEC_A);
        check("min_bound_value", values_a, 32'h0000_0002);
        check("min_bound_upd", upd_cnt_a - c0, 32'd1);

        // ---- saturation with STEP=2 on dut_b ----
        c0 = upd_cnt_b;
        tap(KEY_INC_B);
        check("sat_254_inc", 32'(values_b[7:0]), 32'd255);
        tap(KEY_INC_B);
        check("sat_255_inc", 32'(values_b[7:0]), 32'd255);
        check("sat_upd_count", upd_cnt_b - c0, 32'd2);
        check("sat_dir", 32'(dir_b), 32'd1);
        for (int i = 0; i < 127; i++) begin
            tap(KEY_DEC_B);
        end
        check("sat_walk_down", 32'(values_b[7:0]), 32'd1);
        tap(KEY_DEC_B);
        check("sat_1_dec", 32'(values_b[7:0]), 32'd0);
        c0 = upd_cnt_b;
        tap(KEY_DEC_B);
        check("sat_0_dec", 32'(values_b[7:0]), 32'd0);
        check("sat_0_upd", upd_cnt_b - c0, 32'd1);
        check("sat_0_dir", 32'(dir_b), 32'd0);
        check("sat_other_ch", values_b[31:8], 32'h00FE_FEFE);

        // ---- long hold on ch2 ----
        tap(KEY_SEL_A);
        check("ar_sel", 32'(selo_a), 32'd2);
        nsteps = 0;
        first  = 0;
        second = 0;
        third  = 0;
        inc_a  = 1'b0;
        // Raw release is first sampled 41 cycles after the first step, so the
        // owner is seen released before the +50 repeat: steps at +0,+20,+25,...,+45.
        for (int n = 1; n <= 120; n++) begin
            @(negedge clk);
            if (upd_a) begin
                nsteps++;
                if (nsteps == 1) first = n;
                else if (nsteps == 2) second = n;
                else if (nsteps == 3) third = n;
            end
            if ((first != 0 && n == first + 40) || n == 100) inc_a = 1'b1;
        end
        waitn(5);
        check("ar_first", 32'(first), 32'd9);
`ifdef PARAM_BANK_AUTOREPEAT_EN
        check("ar_steps", 32'(nsteps), 32'd7);
        check("ar_hold_gap", 32'(second - first), 32'd20);
        check("ar_repeat_gap", 32'(third - second), 32'd5);
        check("ar_value", values_a, 32'h0007_0002);
`else
        check("ar_steps", 32'(nsteps), 32'd1);
        check("ar_value", values_a, 32'h0001_0002);
`endif

        // ---- inc and dec in the same cycle: no step until both released ----
        c0    = upd_cnt_a;
        inc_a = 1'b0;
        dec_a = 1'b0;
        waitn(15);
        inc_a = 1'b1;
        dec_a = 1'b1;
        waitn(12);
        check("conflict_upd", upd_cnt_a - c0, 32'd0);
`ifdef PARAM_BANK_AUTOREPEAT_EN
        check("conflict_value", values_a, 32'h0007_0002);
        tap(KEY_INC_A);
        check("conflict_unlock", values_a, 32'h0008_0002);
`else
        check("conflict_value", values_a, 32'h0001_0002);
        tap(KEY_INC_A);
        check("conflict_unlock", values_a, 32'h0002_0002);
`endif

        // ---- sel and inc in the same cycle: sel wins, inc discarded ----
        c0    = upd_cnt_a;
        sel_a = 1'b0;
        inc_a = 1'b0;
        waitn(10);
        sel_a = 1'b1;
        inc_a = 1'b1;
        waitn(12);
        check("selinc_sel", 32'(selo_a), 32'd3);
        check("selinc_upd", upd_cnt_a - c0, 32'd0);
        tap(KEY_INC_A);
`ifdef PARAM_BANK_AUTOREPEAT_EN
        check("selinc_after", values_a, 32'h0108_0002);
`else
        check("selinc_after", values_a, 32'h0102_0002);
`endif

        // ---- reset in the middle of a hold ----
        tap(KEY_SEL_A);
        check("mid_sel", 32'(selo_a), 32'd0);
        inc_a = 1'b0;
        waitn(36);
`ifdef PARAM_BANK_AUTOREPEAT_EN
        check("mid_value", 32'(values_a[7:0]), 32'd5);
`else
        check("mid_value", 32'(values_a[7:0]), 32'd3);
`endif
        rst_n = 1'b0;
        waitn(1);
        check("mid_rst_values", values_a, 32'h0);
        check("mid_rst_sel", 32'(selo_a), 32'd0);
        check("mid_rst_upd", 32'(upd_a), 32'd0);
        check("mid_rst_dir", 32'(dir_a), 32'd1);
        inc_a = 1'b1;
        waitn(3);
        rst_n = 1'b1;
        c0 = upd_cnt_a;
        waitn(30);
        check("post_rst_quiet", upd_cnt_a - c0, 32'd0);
        check("post_rst_values", values_a, 32'h0);
        tap(KEY_INC_A);
        check("post_rst_press", values_a, 32'h0000_0001);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
